// File: rtl/algo_mrnw_1rw_wbuf_if.sv
// Host-side and bank-side signal bundle for the buffered multi-write 1RW memory.
interface algo_mrnw_1rw_wbuf_if #(
    parameter int WIDTH   = 64,
    parameter int BITADDR = 13,
    parameter int NUMWRPT = 2
);
    logic                              ready;
    logic                              wr_rdy;
    logic [NUMWRPT-1:0]                write;
    logic [NUMWRPT-1:0][BITADDR-1:0]   wr_adr;
    logic [NUMWRPT-1:0][WIDTH-1:0]     din;
    logic                              rd_rdy;
    logic                              read;
    logic [BITADDR-1:0]                rd_adr;
    logic                              rd_vld;
    logic [WIDTH-1:0]                  rd_dout;
    logic                              t1_readA;
    logic                              t1_writeA;
    logic [BITADDR-1:0]                t1_addrA;
    logic [WIDTH-1:0]                  t1_dinA;
    logic [WIDTH-1:0]                  t1_doutA;

    modport slave (
        input  write, wr_adr, din, read, rd_adr, t1_doutA,
        output ready, wr_rdy, rd_rdy, rd_vld, rd_dout,
               t1_readA, t1_writeA, t1_addrA, t1_dinA
    );
    modport master (
        output write, wr_adr, din, read, rd_adr, t1_doutA,
        input  ready, wr_rdy, rd_rdy, rd_vld, rd_dout,
               t1_readA, t1_writeA, t1_addrA, t1_dinA
    );
endinterface

// File: rtl/algo_mrnw_1rw_wbuf.sv
// N-write/1-read memory on one 1RW bank: writes queue in a FIFO that drains in
// read-free cycles; reads forward from the FIFO; the bank is cleared after reset.
module algo_mrnw_1rw_wbuf #(
    parameter int WIDTH      = 64,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int NUMWRPT    = 2,
    parameter int FIFODEP    = 8,
    parameter int BITFIFO    = 3,
    parameter int HIWAT      = 6,
    parameter int SRAM_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    algo_mrnw_1rw_wbuf_if.slave  bus
);
    localparam int CW = BITFIFO + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               r_state;
    logic [BITADDR-1:0]   r_icnt;
    logic                 r_ready;
    logic [BITFIFO-1:0]   r_rptr, r_wptr;
    logic [CW-1:0]        r_cnt;
    logic [BITADDR-1:0]   r_fadr [FIFODEP];
    logic [WIDTH-1:0]     r_fdat [FIFODEP];
    logic [SRAM_DELAY:0]  r_vld_pipe, r_hit_pipe;
    logic [WIDTH-1:0]     r_fwd_pipe [SRAM_DELAY+1];
    logic                 r_t1_readA, r_t1_writeA, r_rd_vld;
    logic [BITADDR-1:0]   r_t1_addrA;
    logic [WIDTH-1:0]     r_t1_dinA, r_rd_dout;

    logic                 w_wr_rdy, w_rd_rdy, w_racc, w_pop, w_hit;
    logic [NUMWRPT-1:0]   w_wacc;
    logic [CW-1:0]        w_nwr;
    logic [BITFIFO-1:0]   w_slot [NUMWRPT];
    logic [WIDTH-1:0]     w_fdat;

    assign w_wr_rdy = r_ready && (r_cnt <= CW'(FIFODEP - NUMWRPT));
    assign w_rd_rdy = r_ready && (r_cnt < CW'(HIWAT));
    assign w_racc   = bus.read && w_rd_rdy;
    assign w_wacc   = bus.write & {NUMWRPT{w_wr_rdy}};
    assign w_pop    = (r_state == ST_RUN) && !w_racc && (r_cnt != '0);

    // Accepted ports pack into consecutive slots, lowest port index first.
    always_comb begin
        w_nwr = '0;
        for (int p = 0; p < NUMWRPT; p++) begin
            w_slot[p] = r_wptr + w_nwr[BITFIFO-1:0];
            if (w_wacc[p]) w_nwr = w_nwr + CW'(1);
        end
    end

    // Scan oldest to newest so the last hit is the newest pending write.
    always_comb begin
        w_hit  = 1'b0;
        w_fdat = '0;
        for (int k = 0; k < FIFODEP; k++) begin
            if (CW'(k) < r_cnt && r_fadr[r_rptr + BITFIFO'(k)] == bus.rd_adr) begin
                w_hit  = 1'b1;
                w_fdat = r_fdat[r_rptr + BITFIFO'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUMWRPT; p++) begin
            if (w_wacc[p]) begin
                r_fadr[w_slot[p]] <= bus.wr_adr[p];
                r_fdat[w_slot[p]] <= bus.din[p];
            end
        end
        r_fwd_pipe[0] <= w_fdat;
        for (int i = 1; i <= SRAM_DELAY; i++) r_fwd_pipe[i] <= r_fwd_pipe[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_icnt      <= '0;
            r_ready     <= 1'b0;
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_vld_pipe  <= '0;
            r_hit_pipe  <= '0;
            r_t1_readA  <= 1'b0;
            r_t1_writeA <= 1'b0;
            r_t1_addrA  <= '0;
            r_t1_dinA   <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_dout   <= '0;
        end else begin
            r_ready <= (r_state == ST_RUN);
            case (r_state)
                ST_INIT: begin
                    r_t1_writeA <= 1'b1;
                    r_t1_readA  <= 1'b0;
                    r_t1_addrA  <= r_icnt;
                    r_t1_dinA   <= '0;
                    r_icnt      <= r_icnt + BITADDR'(1);
                    if (r_icnt == BITADDR'(NUMADDR - 1)) r_state <= ST_RUN;
                end
                default: begin
                    if (w_racc) begin
                        r_t1_readA  <= 1'b1;
                        r_t1_writeA <= 1'b0;
                        r_t1_addrA  <= bus.rd_adr;
                    end else if (w_pop) begin
                        r_t1_readA  <= 1'b0;
                        r_t1_writeA <= 1'b1;
                        r_t1_addrA  <= r_fadr[r_rptr];
                        r_t1_dinA   <= r_fdat[r_rptr];
                    end else begin
                        r_t1_readA  <= 1'b0;
                        r_t1_writeA <= 1'b0;
                    end
                end
            endcase
            r_cnt  <= r_cnt + w_nwr - CW'(w_pop);
            r_wptr <= r_wptr + w_nwr[BITFIFO-1:0];
            if (w_pop) r_rptr <= r_rptr + BITFIFO'(1);
            r_vld_pipe[0] <= w_racc;
            r_hit_pipe[0] <= w_hit;
            for (int i = 1; i <= SRAM_DELAY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_hit_pipe[i] <= r_hit_pipe[i-1];
            end
            // Last stage lines up with the bank data for that read.
            r_rd_vld <= r_vld_pipe[SRAM_DELAY];
            if (r_vld_pipe[SRAM_DELAY])
                r_rd_dout <= r_hit_pipe[SRAM_DELAY] ? r_fwd_pipe[SRAM_DELAY] : bus.t1_doutA;
        end
    end

    assign bus.ready     = r_ready;
    assign bus.wr_rdy    = w_wr_rdy;
    assign bus.rd_rdy    = w_rd_rdy;
    assign bus.rd_vld    = r_rd_vld;
    assign bus.rd_dout   = r_rd_dout;
    assign bus.t1_readA  = r_t1_readA;
    assign bus.t1_writeA = r_t1_writeA;
    assign bus.t1_addrA  = r_t1_addrA;
    assign bus.t1_dinA   = r_t1_dinA;
endmodule

// File: tb/tb_algo_mrnw_1rw_wbuf.sv
// Directed bench: init sweep, per-cycle vector table, backpressure burst, mid-op reset.
module tb_algo_mrnw_1rw_wbuf;
    localparam int WIDTH = 64, NUMADDR = 16, BITADDR = 4, NUMWRPT = 2;
    localparam int FIFODEP = 8, BITFIFO = 3, HIWAT = 6, SRAM_DELAY = 1;
    localparam int NV = 36;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    algo_mrnw_1rw_wbuf_if #(.WIDTH(WIDTH), .BITADDR(BITADDR), .NUMWRPT(NUMWRPT)) bus ();

    algo_mrnw_1rw_wbuf #(
        .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR), .NUMWRPT(NUMWRPT),
        .FIFODEP(FIFODEP), .BITFIFO(BITFIFO), .HIWAT(HIWAT), .SRAM_DELAY(SRAM_DELAY)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Bank model, seeded with garbage so the init sweep is observable.
    logic [WIDTH-1:0] mem [NUMADDR] = '{default: 64'hDEAD_BEEF_0000_0000};
    logic [WIDTH-1:0] rdq = '0;
    always @(posedge clk) begin
        if (bus.t1_writeA) mem[bus.t1_addrA] <= bus.t1_dinA;
        if (bus.t1_readA)  rdq <= mem[bus.t1_addrA];
    end
    assign bus.t1_doutA = rdq;

    typedef struct {
        logic [1:0]  wr;
        logic [3:0]  a0;
        logic [63:0] d0;
        logic [3:0]  a1;
        logic [63:0] d1;
        logic        rd;
        logic [3:0]  ra;
        logic        e_rr, e_wr, e_vld;
        logic [63:0] e_dout;
        logic        e_tw, e_tr;
        logic [3:0]  e_ta;
        logic [63:0] e_td;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t v(input logic [1:0] wr, input logic [3:0] a0, input logic [63:0] d0,
                               input logic [3:0] a1, input logic [63:0] d1,
                               input logic rd, input logic [3:0] ra,
                               input logic err, input logic ewr, input logic evld, input logic [63:0] edout,
                               input logic etw, input logic etr, input logic [3:0] eta, input logic [63:0] etd);
        vec_t x;
        x.wr = wr; x.a0 = a0; x.d0 = d0; x.a1 = a1; x.d1 = d1; x.rd = rd; x.ra = ra;
        x.e_rr = err; x.e_wr = ewr; x.e_vld = evld; x.e_dout = edout;
        x.e_tw = etw; x.e_tr = etr; x.e_ta = eta; x.e_td = etd;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wr, input logic [3:0] a0, input logic [63:0] d0,
                         input logic [3:0] a1, input logic [63:0] d1,
                         input logic rd, input logic [3:0] ra);
        bus.write     = wr;
        bus.wr_adr[0] = a0;
        bus.din[0]    = d0;
        bus.wr_adr[1] = a1;
        bus.din[1]    = d1;
        bus.read      = rd;
        bus.rd_adr    = ra;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ready"},     64'(bus.ready),     64'd0);
        chk({tag, " wr_rdy"},    64'(bus.wr_rdy),    64'd0);
        chk({tag, " rd_rdy"},    64'(bus.rd_rdy),    64'd0);
        chk({tag, " rd_vld"},    64'(bus.rd_vld),    64'd0);
        chk({tag, " rd_dout"},   bus.rd_dout,        64'd0);
        chk({tag, " t1_readA"},  64'(bus.t1_readA),  64'd0);
        chk({tag, " t1_writeA"}, 64'(bus.t1_writeA), 64'd0);
        chk({tag, " t1_addrA"},  64'(bus.t1_addrA),  64'd0);
        chk({tag, " t1_dinA"},   bus.t1_dinA,        64'd0);
    endtask

    // Runs the init sweep after reset release; leaves the bench in the first ready cycle.
    task automatic init_sweep(input string tag);
        for (int e = 1; e <= NUMADDR; e++) begin
            tick();
            chk($sformatf("%s init%0d t1_writeA", tag, e), 64'(bus.t1_writeA), 64'd1);
            chk($sformatf("%s init%0d t1_addrA", tag, e),  64'(bus.t1_addrA),  64'(e - 1));
            chk($sformatf("%s init%0d t1_dinA", tag, e),   bus.t1_dinA,        64'd0);
            chk($sformatf("%s init%0d ready", tag, e),     64'(bus.ready),     64'd0);
            chk($sformatf("%s init%0d rd_vld", tag, e),    64'(bus.rd_vld),    64'd0);
        end
        tick();
        chk({tag, " ready up"},        64'(bus.ready),     64'd1);
        chk({tag, " post-init t1_wr"}, 64'(bus.t1_writeA), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows 0-18: basic read, same-cycle dual write, forwarding, read/write collision.
        tbl[0]  = v(2'b00, 0, 0,    0, 0,     1, 5,  1,1,0,0,      0,0,0,0);
        tbl[1]  = v(2'b11, 3, 'hAA, 3, 'hBB,  0, 0,  1,1,0,0,      0,1,5,0);
        tbl[2]  = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      0,0,0,0);
        tbl[3]  = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,0,      1,0,3,'hAA);
        tbl[4]  = v(2'b00, 0, 0,    0, 0,     1, 3,  1,1,0,0,      1,0,3,'hBB);
        tbl[5]  = v(2'b01, 7, 'h55, 0, 0,     0, 0,  1,1,0,0,      0,1,3,0);
        tbl[6]  = v(2'b00, 0, 0,    0, 0,     1, 7,  1,1,0,0,      0,0,0,0);
        tbl[7]  = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'hBB,   0,1,7,0);
        tbl[8]  = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      1,0,7,'h55);
        tbl[9]  = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'h55,   0,0,0,0);
        tbl[10] = v(2'b10, 0, 0,    9, 'h11,  0, 0,  1,1,0,0,      0,0,0,0);
        tbl[11] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      0,0,0,0);
        tbl[12] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      1,0,9,'h11);
        tbl[13] = v(2'b01, 9, 'h22, 0, 0,     1, 9,  1,1,0,0,      0,0,0,0);
        tbl[14] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      0,1,9,0);
        tbl[15] = v(2'b00, 0, 0,    0, 0,     1, 9,  1,1,0,0,      1,0,9,'h22);
        tbl[16] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'h11,   0,1,9,0);
        tbl[17] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      0,0,0,0);
        tbl[18] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'h22,   0,0,0,0);
        // Rows 19-35: reads every cycle with dual-write bursts up to the high watermark.
        tbl[19] = v(2'b11, 10,'h100, 11,'h101, 1, 12, 1,1,0,0,     0,0,0,0);
        tbl[20] = v(2'b11, 10,'h102, 11,'h103, 1, 12, 1,1,0,0,     0,1,12,0);
        tbl[21] = v(2'b11, 10,'h104, 11,'h105, 1, 10, 1,1,0,0,     0,1,12,0);
        tbl[22] = v(2'b11, 10,'h106, 11,'h107, 1, 12, 0,1,1,0,     0,1,10,0);
        tbl[23] = v(2'b00, 0, 0,    0, 0,     1, 12, 0,0,1,0,      1,0,10,'h100);
        tbl[24] = v(2'b00, 0, 0,    0, 0,     1, 12, 0,1,1,'h102,  1,0,11,'h101);
        tbl[25] = v(2'b00, 0, 0,    0, 0,     1, 11, 1,1,0,0,      1,0,10,'h102);
        tbl[26] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      0,1,11,0);
        tbl[27] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      1,0,11,'h103);
        tbl[28] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'h107,  1,0,10,'h104);
        tbl[29] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      1,0,11,'h105);
        tbl[30] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      1,0,10,'h106);
        tbl[31] = v(2'b00, 0, 0,    0, 0,     1, 10, 1,1,0,0,      1,0,11,'h107);
        tbl[32] = v(2'b00, 0, 0,    0, 0,     1, 11, 1,1,0,0,      0,1,10,0);
        tbl[33] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,0,0,      0,1,11,0);
        tbl[34] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'h106,  0,0,0,0);
        tbl[35] = v(2'b00, 0, 0,    0, 0,     0, 0,  1,1,1,'h107,  0,0,0,0);

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b1;
        init_sweep("first");

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("row%0d rd_rdy", i),    64'(bus.rd_rdy),    64'(tbl[i].e_rr));
            chk($sformatf("row%0d wr_rdy", i),    64'(bus.wr_rdy),    64'(tbl[i].e_wr));
            chk($sformatf("row%0d rd_vld", i),    64'(bus.rd_vld),    64'(tbl[i].e_vld));
            if (tbl[i].e_vld)
                chk($sformatf("row%0d rd_dout", i), bus.rd_dout, tbl[i].e_dout);
            chk($sformatf("row%0d t1_writeA", i), 64'(bus.t1_writeA), 64'(tbl[i].e_tw));
            chk($sformatf("row%0d t1_readA", i),  64'(bus.t1_readA),  64'(tbl[i].e_tr));
            if (tbl[i].e_tw || tbl[i].e_tr)
                chk($sformatf("row%0d t1_addrA", i), 64'(bus.t1_addrA), 64'(tbl[i].e_ta));
            if (tbl[i].e_tw)
                chk($sformatf("row%0d t1_dinA", i), bus.t1_dinA, tbl[i].e_td);
            drive(tbl[i].wr, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].rd, tbl[i].ra);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Mid-operation reset: 4 queued writes (reads block drains), 2 reads in flight.
        drive(2'b11, 1, 'h1234, 2, 'h5678, 1, 1);
        tick();
        drive(2'b11, 1, 'h9abc, 2, 'hdef0, 1, 2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("pre-reset t1_readA", 64'(bus.t1_readA), 64'd1);
        chk("pre-reset wr_rdy",   64'(bus.wr_rdy),   64'd1);
        chk("pre-reset rd_rdy",   64'(bus.rd_rdy),   64'd1);
        rst = 1'b0;
        #1;
        chk_zero("midreset");
        tick();
        tick();
        chk_zero("midreset hold");
        rst = 1'b1;
        init_sweep("second");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post-reinit%0d rd_rdy", i),    64'(bus.rd_rdy),    64'd1);
            chk($sformatf("post-reinit%0d wr_rdy", i),    64'(bus.wr_rdy),    64'd1);
            chk($sformatf("post-reinit%0d t1_writeA", i), 64'(bus.t1_writeA), 64'd0);
            chk($sformatf("post-reinit%0d rd_vld", i),    64'(bus.rd_vld),    64'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("reinit rd_vld early", 64'(bus.rd_vld), 64'd0);
        tick();
        chk("reinit rd_vld",  64'(bus.rd_vld), 64'd1);
        chk("reinit rd_dout", bus.rd_dout,     64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/algo_mrnw_1rw_wbuf.md
Name: algo_mrnw_1rw_wbuf

Overview:
- Multi-write-port, single-read-port memory algorithm built on one single-port (1RW) physical bank.
- Write ports are parameterised (NUMWRPT). Writes are buffered in an in-order write FIFO and drained to the bank in cycles with no read.
- Reads are serviced from the bank, with forwarding from pending FIFO entries.
- Adds what the fixed 1R2W wrapper lacked: write/read backpressure, a high-watermark forced drain, and a memory-clear init sequence gating ready.

Parameters:
- WIDTH, 64, data width per port
- NUMADDR, 8192, logical depth
- BITADDR, 13, address width, clog2(NUMADDR)
- NUMWRPT, 2, number of write ports (1..4)
- FIFODEP, 8, write FIFO entries (power of two, >= 2*NUMWRPT)
- BITFIFO, 3, log2(FIFODEP)
- HIWAT, 6, FIFO occupancy at or above which reads are refused
- SRAM_DELAY, 1, physical bank read latency in cycles (t1_readA to t1_doutA)

Ports:
- clk, input, 1, clock; all logic on rising edge
- rst, input, 1, asynchronous active-low reset
- ready, output, 1, init complete; block accepting traffic
- wr_rdy, output, 1, FIFO can accept NUMWRPT writes this cycle
- write, input, NUMWRPT, per-port write request
- wr_adr, input, NUMWRPT*BITADDR, per-port write address
- din, input, NUMWRPT*WIDTH, per-port write data
- rd_rdy, output, 1, read may be issued this cycle
- read, input, 1, read request
- rd_adr, input, BITADDR, read address
- rd_vld, output, 1, read data valid
- rd_dout, output, WIDTH, read data
- t1_readA, output, 1, bank read strobe (registered)
- t1_writeA, output, 1, bank write strobe (registered)
- t1_addrA, output, BITADDR, bank address (registered)
- t1_dinA, output, WIDTH, bank write data (registered)
- t1_doutA, input, WIDTH, bank read data, valid SRAM_DELAY cycles after t1_readA

Behaviour:
- Reset (rst=0, async):
  - ready, wr_rdy, rd_rdy, rd_vld, t1_readA, t1_writeA = 0.
  - t1_addrA, t1_dinA, rd_dout = 0.
  - FIFO pointers and count = 0; read pipeline flushed; FSM = INIT, init counter = 0.
- FSM INIT:
  - Each cycle, register t1_writeA=1, t1_addrA=counter, t1_dinA=0; increment the counter.
  - After address NUMADDR-1 is written, go to RUN; ready rises the next cycle. This takes NUMADDR cycles.
  - read/write are ignored in INIT.
- FSM RUN: stays in RUN until reset. Reset mid-operation discards the FIFO and in-flight reads, then re-enters INIT.
- Write acceptance:
  - wr_rdy = ready && (count <= FIFODEP-NUMWRPT).
  - Writes with wr_rdy=0 are dropped; the bench must not issue them.
  - Accepted ports are enqueued in ascending port index, so the higher index is newer.
  - Same-cycle writes to one address: all are enqueued; the highest index lands last in the bank.
- Read acceptance:
  - rd_rdy = ready && (count < HIWAT).
  - An accepted read takes the bank in cycle c: t1_readA=1 and t1_addrA=rd_adr are registered at c+1.
- Drain:
  - In RUN, in a cycle with no accepted read and count>0, pop the FIFO head.
  - Register t1_writeA=1 with the head address and data.
  - Read and drain are never issued in the same cycle.
- Count: updates as count + accepted writes - pop. Pointers wrap modulo FIFODEP.
- Forwarding:
  - At acceptance cycle c, rd_adr is compared against all valid FIFO entries as present at the start of c. Writes accepted in c are not visible to that read.
  - On a hit, the newest matching entry's data is captured and piped with the read.
- Read latency: rd_vld=1 at cycle c+2+SRAM_DELAY. rd_dout = forwarded data on hit, else t1_doutA (registered).
- Reads are fully pipelined: one per cycle while rd_rdy=1.
- Bank ordering: a drain popped in cycle k writes at k+1. Any read accepted at k+1 or later reads at k+2 or later, so it sees the new data.

Test Plan:
- Reset release with NUMADDR=16 -> t1_writeA high 16 cycles with addresses 0..15 and din 0; ready=1 at the 17th cycle after reset release; a read of address 5 then returns 0.
- Port0 writes 0xAA to address 3, port1 writes 0xBB to address 3 in the same cycle, then idle -> two bank writes in order; a later read of address 3 returns 0xBB.
- Write 0x55 to address 7, then read address 7 on the next cycle while the FIFO holds it -> forwarded; rd_vld at read cycle +2+SRAM_DELAY with rd_dout=0x55.
- Continuous reads with a 2-write burst every cycle -> count reaches HIWAT=6; rd_rdy drops; drains occur; rd_rdy reasserts at count 5. At count 7, wr_rdy=0 when NUMWRPT=2.
- Read and write to the same address in the same cycle (old value 0x11, new 0x22) -> read returns 0x11; a subsequent read returns 0x22.
- Assert rst with 4 FIFO entries and 2 reads in flight -> all outputs 0 immediately; after release, INIT re-runs; no stale rd_vld appears.
